ahb_rr_arb: RTL and testbench

Round-robin AHB-Lite arbiter that shares one slave port among NUM_MASTERS masters. Losing address phases are buffered per master and replayed later. The block sits in front of a single shared slave (e.g. on-chip RAM) that multiple bus masters reach through the interconnect. Unlike the fixed-priority crossbar, it guarantees starvation-free access and routes write data, read data and responses by a registered data-phase owner.

---
 rtl/ahb_rr_arb.sv | 169 ++++++++++++++++
 tb/tb_ahb_rr_arb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_rr_arb.sv
`timescale 1ns/1ps
// ahb_rr_arb: round-robin AHB-Lite arbiter sharing one slave port among NUM_MASTERS masters.
// Latency: an uncontended address phase reaches the slave in the same cycle; losers replay from a per-master buffer.
// Backpressure: a loser sees hready_m low until its replayed data phase; slave wait states freeze arbitration.
//
// Ports:
//   hclk, hresetn                      clock, asynchronous active-low reset
//   htrans_m/haddr_m/hsize_m/hwrite_m  per-master address phase
//   hwdata_m                           per-master write data (data phase)
//   hrdata_m/hready_m/hresp_m          per-master response, routed to the data-phase owner only
//   hsel_s..hwdata_s                   issued transfer to the shared slave
//   hrdata_s/hready_s/hresp_s          slave response
//   grant_o                            one-hot winner of the current address phase
module ahb_rr_arb #(
    parameter int NUM_MASTERS = 2,
    parameter bit BURST_LOCK  = 1'b1
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [1:0]             htrans_m [NUM_MASTERS-1:0],
    input  logic [31:0]            haddr_m  [NUM_MASTERS-1:0],
    input  logic [2:0]             hsize_m  [NUM_MASTERS-1:0],
    input  logic [NUM_MASTERS-1:0] hwrite_m,
    input  logic [31:0]            hwdata_m [NUM_MASTERS-1:0],
    output logic [31:0]            hrdata_m [NUM_MASTERS-1:0],
    output logic [NUM_MASTERS-1:0] hready_m,
    output logic [NUM_MASTERS-1:0] hresp_m,
    output logic                   hsel_s,
    output logic [1:0]             htrans_s,
    output logic [31:0]            haddr_s,
    output logic [2:0]             hsize_s,
    output logic                   hwrite_s,
    output logic [31:0]            hwdata_s,
    input  logic [31:0]            hrdata_s,
    input  logic                   hready_s,
    input  logic                   hresp_s,
    output logic [NUM_MASTERS-1:0] grant_o
);

    localparam int         IW      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [1:0] TR_IDLE = 2'b00;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    typedef struct packed {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
    } hdr_t;

    hdr_t                   pend [NUM_MASTERS-1:0];
    logic [NUM_MASTERS-1:0] pend_vld;
    logic [NUM_MASTERS-1:0] lreq;
    logic [NUM_MASTERS-1:0] req;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          lock_own;
    logic [IW-1:0]          dp_own;
    logic [IW-1:0]          win_idx;
    logic [IW-1:0]          cand;
    logic                   lock_vld;
    logic                   dp_vld;
    logic                   found;
    logic                   lock_hit;
    logic                   win_vld;
    hdr_t                   live_hdr;
    hdr_t                   iss_hdr;

    // A master is stalled while its transfer sits in the pending buffer, or while
    // it owns the data phase and the slave inserts a wait state. Only an address
    // phase seen with hready_m high counts as a new (live) request.
    always_comb begin
        hready_m = '1;
        lreq     = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            hready_m[m] = ~pend_vld[m] & ~(dp_vld & (int'(dp_own) == m) & ~hready_s);
            lreq[m]     = htrans_m[m][1] & hready_m[m];
        end
        req = pend_vld | lreq;
    end

    // Round-robin search from rr_ptr; a locked burst owner continuing with SEQ
    // overrides the pointer so bursts are not split across masters.
    always_comb begin
        win_idx  = '0;
        cand     = '0;
        found    = 1'b0;
        lock_hit = BURST_LOCK && lock_vld && lreq[lock_own] && (htrans_m[lock_own] == TR_SEQ);
        if (lock_hit) begin
            win_idx = lock_own;
            found   = 1'b1;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                cand = IW'((int'(rr_ptr) + i) % NUM_MASTERS);
                if (!found && req[cand]) begin
                    win_idx = cand;
                    found   = 1'b1;
                end
            end
        end
        // No grant is ever issued into a slave wait state.
        win_vld = hready_s & found;
    end

    // Replayed transfers come from the buffer; otherwise pass the live phase through.
    always_comb begin
        live_hdr.trans = htrans_m[win_idx];
        live_hdr.addr  = haddr_m[win_idx];
        live_hdr.size  = hsize_m[win_idx];
        live_hdr.wr    = hwrite_m[win_idx];
        iss_hdr        = pend_vld[win_idx] ? pend[win_idx] : live_hdr;

        hsel_s   = win_vld;
        htrans_s = win_vld ? iss_hdr.trans : TR_IDLE;
        haddr_s  = win_vld ? iss_hdr.addr  : '0;
        hsize_s  = win_vld ? iss_hdr.size  : '0;
        hwrite_s = win_vld & iss_hdr.wr;
        grant_o  = win_vld ? (NUM_MASTERS'(1) << win_idx) : '0;
    end

    // Data-phase routing keyed on the registered owner.
    always_comb begin
        hwdata_s = dp_vld ? hwdata_m[dp_own] : '0;
        hresp_m  = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            hrdata_m[m] = (dp_vld && (int'(dp_own) == m)) ? hrdata_s : '0;
            hresp_m[m]  = dp_vld & (int'(dp_own) == m) & hresp_s;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_own <= '0;
            dp_vld   <= 1'b0;
            dp_own   <= '0;
            pend_vld <= '0;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                pend[m] <= '0;
            end
        end else begin
            // Arbitration state, data-phase owner and lock all hold through wait states.
            if (hready_s) begin
                dp_vld   <= win_vld;
                lock_vld <= BURST_LOCK & win_vld & iss_hdr.trans[1];
                if (win_vld) begin
                    dp_own   <= win_idx;
                    lock_own <= win_idx;
                    rr_ptr   <= IW'((int'(win_idx) + 1) % NUM_MASTERS);
                end
            end
            // A live request that did not win (including every request during a
            // wait state) is parked; a parked entry is released when it wins.
            // lreq already excludes masters with a parked entry, so the two never collide.
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (win_vld && (int'(win_idx) == m)) begin
                    pend_vld[m] <= 1'b0;
                end else if (lreq[m]) begin
                    pend_vld[m]   <= 1'b1;
                    pend[m].trans <= htrans_m[m];
                    pend[m].addr  <= haddr_m[m];
                    pend[m].size  <= hsize_m[m];
                    pend[m].wr    <= hwrite_m[m];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_rr_arb.sv
`timescale 1ns/1ps
// tb_ahb_rr_arb: scenario tasks for the round-robin AHB arbiter with a grant scoreboard.
// Latency: bench drives at posedge+1 and samples at negedge.
// Backpressure: master models advance their address only when hready_m was high.
module tb_ahb_rr_arb;

    localparam int         N      = 2;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic [1:0]    htrans_m [N-1:0];
    logic [31:0]   haddr_m  [N-1:0];
    logic [2:0]    hsize_m  [N-1:0];
    logic [N-1:0]  hwrite_m;
    logic [31:0]   hwdata_m [N-1:0];
    logic [31:0]   hrdata_m [N-1:0];
    logic [N-1:0]  hready_m;
    logic [N-1:0]  hresp_m;
    logic          hsel_s;
    logic [1:0]    htrans_s;
    logic [31:0]   haddr_s;
    logic [2:0]    hsize_s;
    logic          hwrite_s;
    logic [31:0]   hwdata_s;
    logic [31:0]   hrdata_s;
    logic          hready_s;
    logic          hresp_s;
    logic [N-1:0]  grant_o;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic        wr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    ahb_rr_arb #(.NUM_MASTERS(N), .BURST_LOCK(1'b1)) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .htrans_m (htrans_m),
        .haddr_m  (haddr_m),
        .hsize_m  (hsize_m),
        .hwrite_m (hwrite_m),
        .hwdata_m (hwdata_m),
        .hrdata_m (hrdata_m),
        .hready_m (hready_m),
        .hresp_m  (hresp_m),
        .hsel_s   (hsel_s),
        .htrans_s (htrans_s),
        .haddr_s  (haddr_s),
        .hsize_s  (hsize_s),
        .hwrite_s (hwrite_s),
        .hwdata_s (hwdata_s),
        .hrdata_s (hrdata_s),
        .hready_s (hready_s),
        .hresp_s  (hresp_s),
        .grant_o  (grant_o)
    );

    always #5 hclk = ~hclk;

    // Scoreboard: every issued address phase must match the next expected transfer.
    exp_t         sb_e;
    logic [N-1:0] sb_g;
    always @(negedge hclk) begin
        if (hresetn === 1'b1 && hsel_s === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: grant=%b addr=%h but no transfer expected", grant_o, haddr_s);
            end else begin
                sb_e = exp_q.pop_front();
                sb_g = '0;
                sb_g[sb_e.idx] = 1'b1;
                if (grant_o !== sb_g || haddr_s !== sb_e.addr || hwrite_s !== sb_e.wr || htrans_s[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL sb_grant: got grant=%b addr=%h wr=%b trans=%b, want grant=%b addr=%h wr=%b",
                             grant_o, haddr_s, hwrite_s, htrans_s, sb_g, sb_e.addr, sb_e.wr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_all();
        for (int m = 0; m < N; m++) begin
            htrans_m[m] = IDLE;
            haddr_m[m]  = '0;
            hsize_m[m]  = '0;
            hwdata_m[m] = '0;
        end
        hwrite_m = '0;
    endtask

    task automatic test_reset();
        hresetn  = 1'b0;
        hready_s = 1'b1;
        hrdata_s = 32'hDEAD_BEEF;
        hresp_s  = 1'b1;
        idle_all();
        hwdata_m[0] = 32'h1111_1111;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        checks++; if (hready_m !== 2'b11) begin failures++; $display("FAIL rst_hready: got %b want 11", hready_m); end
        checks++; if (hsel_s !== 1'b0) begin failures++; $display("FAIL rst_hsel: got %b want 0", hsel_s); end
        checks++; if (htrans_s !== IDLE) begin failures++; $display("FAIL rst_htrans: got %b want 00", htrans_s); end
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL rst_grant: got %b want 00", grant_o); end
        checks++; if (hwdata_s !== 32'h0) begin failures++; $display("FAIL rst_hwdata: got %h want 0", hwdata_s); end
        checks++; if (hrdata_m[0] !== 32'h0) begin failures++; $display("FAIL rst_hrdata0: got %h want 0", hrdata_m[0]); end
        checks++; if (hresp_m !== 2'b00) begin failures++; $display("FAIL rst_hresp: got %b want 00", hresp_m); end
        checks++; if (haddr_s !== 32'h0) begin failures++; $display("FAIL rst_haddr: got %h want 0", haddr_s); end
        @(posedge hclk);
        #1;
        hresetn     = 1'b1;
        hresp_s     = 1'b0;
        hwdata_m[0] = '0;
    endtask

    task automatic test_contention();
        htrans_m[0] = NONSEQ; haddr_m[0] = 32'h0000_0100;
        htrans_m[1] = NONSEQ; haddr_m[1] = 32'h0000_0200;
        exp_q.push_back('{0, 32'h0000_0100, 1'b0});
        exp_q.push_back('{1, 32'h0000_0200, 1'b0});
        @(negedge hclk);
        checks++; if (hready_m[1] !== 1'b1) begin failures++; $display("FAIL cont_rdy1_addr: got %b want 1", hready_m[1]); end
        tick();
        idle_all();
        haddr_m[1] = 32'hBAD0_0000;
        @(negedge hclk);
        checks++; if (hready_m[1] !== 1'b0) begin failures++; $display("FAIL cont_rdy1_wait: got %b want 0", hready_m[1]); end
        checks++; if (haddr_s !== 32'h0000_0200) begin failures++; $display("FAIL cont_replay_addr: got %h want 00000200", haddr_s); end
        tick();
        @(negedge hclk);
        checks++; if (hready_m[1] !== 1'b1) begin failures++; $display("FAIL cont_rdy1_data: got %b want 1", hready_m[1]); end
        checks++; if (dut.rr_ptr !== 1'b0) begin failures++; $display("FAIL cont_rr_ptr: got %0d want 0", dut.rr_ptr); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL cont_drain: got %0d left want 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_alternate();
        int           k[N];
        int           cnt[N];
        logic [N-1:0] acc;
        k   = '{0, 0};
        cnt = '{0, 0};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{0, 32'h1000_0000 + 32'(4 * i), 1'b0});
            exp_q.push_back('{1, 32'h1100_0000 + 32'(4 * i), 1'b0});
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            for (int m = 0; m < N; m++) begin
                htrans_m[m] = (k[m] < 4) ? NONSEQ : IDLE;
                haddr_m[m]  = ((m == 0) ? 32'h1000_0000 : 32'h1100_0000) + 32'(4 * k[m]);
            end
            @(negedge hclk);
            acc = hready_m;
            for (int m = 0; m < N; m++) if (grant_o[m] === 1'b1) cnt[m]++;
            tick();
            for (int m = 0; m < N; m++) if (acc[m] && k[m] < 4) k[m]++;
        end
        idle_all();
        checks++; if (cnt[0] != 4) begin failures++; $display("FAIL alt_cnt0: got %0d want 4", cnt[0]); end
        checks++; if (cnt[1] != 4) begin failures++; $display("FAIL alt_cnt1: got %0d want 4", cnt[1]); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL alt_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_single_read();
        htrans_m[0] = NONSEQ; haddr_m[0] = 32'h2000_0010; hsize_m[0] = 3'd2;
        exp_q.push_back('{0, 32'h2000_0010, 1'b0});
        @(negedge hclk);
        checks++; if (hsel_s !== 1'b1) begin failures++; $display("FAIL rd_hsel: got %b want 1", hsel_s); end
        checks++; if (haddr_s !== 32'h2000_0010) begin failures++; $display("FAIL rd_haddr: got %h want 20000010", haddr_s); end
        checks++; if (hsize_s !== 3'd2) begin failures++; $display("FAIL rd_hsize: got %0d want 2", hsize_s); end
        tick();
        idle_all();
        hrdata_s = 32'h1234_5678;
        hresp_s  = 1'b1;
        @(negedge hclk);
        checks++; if (hrdata_m[0] !== 32'h1234_5678) begin failures++; $display("FAIL rd_data0: got %h want 12345678", hrdata_m[0]); end
        checks++; if (hrdata_m[1] !== 32'h0) begin failures++; $display("FAIL rd_data1: got %h want 0", hrdata_m[1]); end
        checks++; if (hresp_m !== 2'b01) begin failures++; $display("FAIL rd_resp: got %b want 01", hresp_m); end
        tick();
        hresp_s = 1'b0;
    endtask

    task automatic test_stall();
        htrans_m[1] = NONSEQ; haddr_m[1] = 32'h0000_0300; hwrite_m[1] = 1'b1;
        exp_q.push_back('{1, 32'h0000_0300, 1'b1});
        @(negedge hclk);
        tick();
        idle_all();
        hwdata_m[1] = 32'hCAFE_0001;
        hready_s    = 1'b0;
        htrans_m[0] = NONSEQ; haddr_m[0] = 32'h0000_0400;
        exp_q.push_back('{0, 32'h0000_0400, 1'b0});
        for (int c = 0; c < 3; c++) begin
            @(negedge hclk);
            checks++; if (hwdata_s !== 32'hCAFE_0001) begin failures++; $display("FAIL stall_wdata c%0d: got %h want cafe0001", c, hwdata_s); end
            checks++; if (hready_m[1] !== 1'b0) begin failures++; $display("FAIL stall_rdy1 c%0d: got %b want 0", c, hready_m[1]); end
            checks++; if (hsel_s !== 1'b0) begin failures++; $display("FAIL stall_hsel c%0d: got %b want 0", c, hsel_s); end
            if (c > 0) begin
                checks++; if (hready_m[0] !== 1'b0) begin failures++; $display("FAIL stall_buf0 c%0d: got %b want 0", c, hready_m[0]); end
            end
            tick();
            htrans_m[0] = IDLE;
            haddr_m[0]  = 32'hBAD0_0004;
        end
        hready_s = 1'b1;
        @(negedge hclk);
        checks++; if (hready_m[1] !== 1'b1) begin failures++; $display("FAIL stall_rdy1_end: got %b want 1", hready_m[1]); end
        checks++; if (hwdata_s !== 32'hCAFE_0001) begin failures++; $display("FAIL stall_wdata_end: got %h want cafe0001", hwdata_s); end
        tick();
        idle_all();
        @(negedge hclk);
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_drain: got %0d left want 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_burst_lock();
        int           k;
        logic         done0;
        logic [N-1:0] acc;
        k     = 0;
        done0 = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back('{1, 32'h0000_3000 + 32'(4 * i), 1'b0});
        exp_q.push_back('{0, 32'h0000_4000, 1'b0});
        for (int cyc = 0; cyc < 8; cyc++) begin
            htrans_m[1] = (k >= 4) ? IDLE : ((k == 0) ? NONSEQ : SEQ);
            haddr_m[1]  = 32'h0000_3000 + 32'(4 * k);
            htrans_m[0] = done0 ? IDLE : NONSEQ;
            haddr_m[0]  = 32'h0000_4000;
            @(negedge hclk);
            acc = hready_m;
            tick();
            if (acc[1] && k < 4) k++;
            if (acc[0]) done0 = 1'b1;
        end
        idle_all();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL lock_drain: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        hready_s    = 1'b0;
        htrans_m[1] = NONSEQ;
        haddr_m[1]  = 32'h0000_0500;
        @(negedge hclk);
        tick();
        idle_all();
        @(negedge hclk);
        checks++; if (hready_m[1] !== 1'b0) begin failures++; $display("FAIL rmid_pending: got %b want 0", hready_m[1]); end
        #1;
        hresetn = 1'b0;
        #1;
        checks++; if (hready_m !== 2'b11) begin failures++; $display("FAIL rmid_hready: got %b want 11", hready_m); end
        checks++; if (hsel_s !== 1'b0) begin failures++; $display("FAIL rmid_hsel: got %b want 0", hsel_s); end
        tick();
        hready_s = 1'b1;
        tick();
        hresetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge hclk);
            checks++; if (hsel_s !== 1'b0) begin failures++; $display("FAIL rmid_noreplay c%0d: got %b want 0", c, hsel_s); end
            checks++; if (hready_m !== 2'b11) begin failures++; $display("FAIL rmid_rdy c%0d: got %b want 11", c, hready_m); end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rmid_drain: got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_alternate();
        test_single_read();
        test_stall();
        test_burst_lock();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
